// File: rtl/ram_loader_pkg.sv
// Shared constants for the RAM loader path; RAM_ADDR_BITS must match the
// width used by the attached ram block.
package ram_loader_pkg;

  localparam int unsigned RAM_ADDR_BITS = 13;

endpackage

// File: rtl/ram_loader.sv
// Sequential byte loader/dumper for the single-port ram: streams a load byte
// stream into consecutive addresses, or streams consecutive addresses out.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_BITS = RAM_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dump,
  input  logic [ADDR_BITS-1:0] cmd_base,
  input  logic [ADDR_BITS:0]   cmd_len,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_di,
  input  logic [7:0]           ram_do
);

  typedef enum logic [2:0] {StIdle, StLoad, StDumpRd, StDumpCap, StDumpOut} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [ADDR_BITS:0]   remaining_q, remaining_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;
  logic                 last;

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign in_ready  = (state_q == StLoad);
  // Abort suppresses the write in the same cycle so no byte lands after a cancel.
  assign ram_we    = (state_q == StLoad) && in_valid && !abort;
  assign ram_di    = ram_we ? in_data : 8'h00;
  assign ram_addr  = ptr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign last      = (remaining_q == (ADDR_BITS + 1)'(1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          ptr_d       = cmd_base;
          remaining_d = cmd_len;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = cmd_dump ? StDumpRd : StLoad;
          end
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else if (in_valid) begin
          ptr_d       = ptr_q + ADDR_BITS'(1);
          remaining_d = remaining_q - (ADDR_BITS + 1)'(1);
          if (last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StDumpRd: begin
        state_d = abort ? StIdle : StDumpCap;
      end
      StDumpCap: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          out_data_d  = ram_do;
          out_valid_d = 1'b1;
          state_d     = StDumpOut;
        end
      end
      StDumpOut: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          remaining_d = remaining_q - (ADDR_BITS + 1)'(1);
          if (last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            ptr_d   = ptr_q + ADDR_BITS'(1);
            state_d = StDumpRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural registered-read RAM attached.
module tb_ram_loader;

  localparam int unsigned AB = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_dump;
  logic [AB-1:0] cmd_base;
  logic [AB:0]   cmd_len;
  logic          abort;
  logic          in_valid, in_ready;
  logic [7:0]    in_data;
  logic          out_valid, out_ready;
  logic [7:0]    out_data;
  logic          busy, done;
  logic          ram_we;
  logic [AB-1:0] ram_addr;
  logic [7:0]    ram_di, ram_do;

  logic [7:0]    mem [0:(1<<AB)-1];
  logic [7:0]    byte_buf [8];
  int            n_pass = 0;
  int            n_total = 0;

  ram_loader #(.ADDR_BITS(AB)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dump (cmd_dump),
    .cmd_base (cmd_base),
    .cmd_len  (cmd_len),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .done     (done),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_do   (ram_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_di;
    ram_do <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic load_run(input logic [AB-1:0] base, input int n);
    logic [AB-1:0] a;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dump = 1'b0; cmd_base = base; cmd_len = (AB + 1)'(n);
    #1 check("ld_cmd_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0; in_valid = 1'b1; in_data = byte_buf[i];
      a = base + AB'(i);
      #1;
      check("ld_in_ready", 32'(in_ready), 1);
      check("ld_we", 32'(ram_we), 1);
      check("ld_addr", 32'(ram_addr), 32'(a));
      check("ld_di", 32'(ram_di), 32'(byte_buf[i]));
      check("ld_no_early_done", 32'(done), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("ld_done", 32'(done), 1);
    check("ld_cmd_ready_at_done", 32'(cmd_ready), 1);
    check("ld_busy_at_done", 32'(busy), 0);
    check("ld_we_idle", 32'(ram_we), 0);
    @(negedge clk);
    #1 check("ld_done_one_cycle", 32'(done), 0);
  endtask

  // Dump n bytes and compare with byte_buf; byte stall_idx is held off for stall_cycles.
  task automatic dump_run(input logic [AB-1:0] base, input int n, input int stall_idx,
                          input int stall_cycles);
    int cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dump = 1'b1; cmd_base = base; cmd_len = (AB + 1)'(n);
    out_ready = 1'b0;
    #1 check("dp_cmd_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < n; i++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cmd_valid = 1'b0; out_ready = 1'b0;
        #1 cnt++;
      end while (!out_valid && cnt < 8);
      check("dp_latency", 32'(cnt), 3);
      check("dp_data", 32'(out_data), 32'(byte_buf[i]));
      if (i == stall_idx) begin
        repeat (stall_cycles) begin
          @(negedge clk);
          #1;
          check("dp_hold_valid", 32'(out_valid), 1);
          check("dp_hold_data", 32'(out_data), 32'(byte_buf[i]));
        end
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("dp_done", 32'(done), 1);
    check("dp_valid_cleared", 32'(out_valid), 0);
    check("dp_busy_at_done", 32'(busy), 0);
  endtask

  task automatic zero_len(input logic dump);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dump = dump; cmd_base = 13'h0020; cmd_len = '0;
    #1 check("z_busy_c", 32'(busy), 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("z_done", 32'(done), 1);
    check("z_busy", 32'(busy), 0);
    check("z_we", 32'(ram_we), 0);
    check("z_out_valid", 32'(out_valid), 0);
    check("z_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    #1 check("z_done_cleared", 32'(done), 0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; cmd_valid = 1'b0; cmd_dump = 1'b0; cmd_base = '0; cmd_len = '0;
    abort = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    for (int i = 0; i < (1 << AB); i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_we", 32'(ram_we), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_di", 32'(ram_di), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic load then dump
    byte_buf[0] = 8'hA1; byte_buf[1] = 8'hB2; byte_buf[2] = 8'hC3; byte_buf[3] = 8'hD4;
    load_run(13'h0010, 4);
    check("mem_0x13", 32'(mem[13'h0013]), 32'h D4);
    dump_run(13'h0010, 4, -1, 0);

    // Address wrap
    byte_buf[0] = 8'h5A; byte_buf[1] = 8'h6B; byte_buf[2] = 8'h7C; byte_buf[3] = 8'h8D;
    load_run(13'h1FFE, 4);
    check("wrap_mem_1fff", 32'(mem[13'h1FFF]), 32'h6B);
    check("wrap_mem_0000", 32'(mem[13'h0000]), 32'h7C);
    check("wrap_mem_0001", 32'(mem[13'h0001]), 32'h8D);
    dump_run(13'h1FFE, 4, -1, 0);

    // Zero length
    zero_len(1'b0);
    zero_len(1'b1);

    // Backpressure on the second byte
    byte_buf[0] = 8'hA1; byte_buf[1] = 8'hB2; byte_buf[2] = 8'hC3;
    dump_run(13'h0010, 3, 1, 5);

    // Abort a load after two of five bytes
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dump = 1'b0; cmd_base = 13'h0040; cmd_len = 14'd5;
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk);
    in_data = 8'h22;
    @(negedge clk);
    in_data = 8'h33; abort = 1'b1;
    #1 check("ab_no_we", 32'(ram_we), 0);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    #1;
    check("ab_busy", 32'(busy), 0);
    check("ab_no_done", 32'(done), 0);
    check("ab_cmd_ready", 32'(cmd_ready), 1);
    check("ab_mem_40", 32'(mem[13'h0040]), 32'h11);
    check("ab_mem_41", 32'(mem[13'h0041]), 32'h22);
    check("ab_mem_42", 32'(mem[13'h0042]), 32'h00);
    @(negedge clk);
    #1 check("ab_no_done_late", 32'(done), 0);

    // Abort during DUMP_OUT
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dump = 1'b1; cmd_base = 13'h0010; cmd_len = 14'd4;
    cnt = 0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1 cnt++;
    end while (!out_valid && cnt < 8);
    check("abd_valid_seen", 32'(out_valid), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abd_valid_dropped", 32'(out_valid), 0);
    check("abd_busy", 32'(busy), 0);
    check("abd_no_done", 32'(done), 0);

    // Reset mid-dump with out_valid high
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dump = 1'b1; cmd_base = 13'h0010; cmd_len = 14'd2;
    cnt = 0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1 cnt++;
    end while (!out_valid && cnt < 8);
    check("rd_valid_seen", 32'(out_valid), 1);
    #1 rst = 1'b1;
    #1;
    check("rd_out_valid", 32'(out_valid), 0);
    check("rd_busy", 32'(busy), 0);
    check("rd_we", 32'(ram_we), 0);
    check("rd_addr", 32'(ram_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b1; cmd_dump = 1'b0; cmd_base = 13'h0050; cmd_len = 14'd1;
    #1 check("rd_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    #1;
    check("rd_new_busy", 32'(busy), 1);
    check("rd_new_we", 32'(ram_we), 1);
    check("rd_new_addr", 32'(ram_addr), 32'h50);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("rd_new_done", 32'(done), 1);
    check("rd_new_mem", 32'(mem[13'h0050]), 32'hEE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
